// File: rtl/uc_pkg.sv
// -----------------------------------------------------------------------------
// uc_pkg
// Shared definitions for the sequential control unit:
//   - opcode class field values (Opcode[5:4])
//   - jump subcodes (Opcode[1:0] within the jump class)
//   - the HALT opcode
//   - run-control FSM state encoding
//   - the raw control word produced by the opcode decoder
// -----------------------------------------------------------------------------
package uc_pkg;

    // Opcode class, taken from Opcode[5:4]
    localparam logic [1:0] OP_ALU_RR = 2'b00;
    localparam logic [1:0] OP_ALU_IM = 2'b01;
    localparam logic [1:0] OP_JMP    = 2'b10;
    localparam logic [1:0] OP_SYS    = 2'b11;

    // Jump subcodes, taken from Opcode[1:0]; 2'b11 is reserved and acts as NOP
    localparam logic [1:0] J   = 2'b00;
    localparam logic [1:0] JZ  = 2'b01;
    localparam logic [1:0] JNZ = 2'b10;

    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } state_t;

    // Unqualified decode of one opcode; the top gates it with exec
    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we;
        logic       wez;
        logic [2:0] alu_op;
        logic       is_halt;
    } ctrl_t;

endpackage

// File: rtl/uc_secuencial_if.sv
// -----------------------------------------------------------------------------
// uc_secuencial_if
// Control bus between the control unit and the single-cycle datapath.
//   Opcode[5:0], zero       : datapath -> control unit
//   s_inc, s_inm, we, wez,
//   ALUOp[2:0], pc_en       : control unit -> datapath
// Modports:
//   master : the control unit (drives the control lines)
//   slave  : the datapath side (drives opcode and zero flag)
// -----------------------------------------------------------------------------
interface uc_secuencial_if;

    logic [5:0] Opcode;
    logic       zero;
    logic       s_inc;
    logic       s_inm;
    logic       we;
    logic       wez;
    logic [2:0] ALUOp;
    logic       pc_en;

    modport master (
        input  Opcode,
        input  zero,
        output s_inc,
        output s_inm,
        output we,
        output wez,
        output ALUOp,
        output pc_en
    );

    modport slave (
        output Opcode,
        output zero,
        input  s_inc,
        input  s_inm,
        input  we,
        input  wez,
        input  ALUOp,
        input  pc_en
    );

endinterface

// File: rtl/uc_decode.sv
// -----------------------------------------------------------------------------
// uc_decode
// Purely combinational opcode decoder. Produces the raw control word for one
// instruction without regard to the run-control state.
// Ports:
//   opcode[5:0] : instruction opcode field
//   zero        : registered ALU zero flag (from the last flag-writing instr)
//   ctrl        : raw control word (s_inc, s_inm, we, wez, alu_op, is_halt)
// -----------------------------------------------------------------------------
module uc_decode
    import uc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       zero,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl       = '0;
        ctrl.s_inc = 1'b1;
        case (opcode[5:4])
            OP_ALU_RR: begin
                ctrl.alu_op = opcode[2:0];
                ctrl.we     = 1'b1;
                ctrl.wez    = 1'b1;
            end
            OP_ALU_IM: begin
                ctrl.alu_op = opcode[2:0];
                ctrl.s_inm  = 1'b1;
                ctrl.we     = 1'b1;
                ctrl.wez    = 1'b1;
            end
            OP_JMP: begin
                // s_inc=0 selects the jump target; jumps never touch the flag
                case (opcode[1:0])
                    J:       ctrl.s_inc = 1'b0;
                    JZ:      ctrl.s_inc = ~zero;
                    JNZ:     ctrl.s_inc = zero;
                    default: ctrl.s_inc = 1'b1;
                endcase
            end
            default: begin
                // OP_SYS: only 111111 is meaningful, everything else is NOP
                ctrl.is_halt = (opcode == OP_HALT);
            end
        endcase
    end

endmodule

// File: rtl/uc_secuencial.sv
// -----------------------------------------------------------------------------
// uc_secuencial
// Control unit for the single-cycle microcontroller datapath with run control.
// The opcode decode is combinational; it is only allowed to act on the
// datapath while exec is high, i.e. in RUN, or in STEP during a step pulse.
// Ports:
//   clk          : system clock, rising edge
//   reset        : asynchronous, active-low reset
//   bus          : control bus (Opcode/zero in; s_inc, s_inm, we, wez,
//                  ALUOp, pc_en out), master side
//   start        : level, requests leaving IDLE
//   step_mode    : 1 = execute one instruction per step pulse
//   step         : single-cycle pulse allowing one instruction in step mode
//   halted       : 1 while in HALT (registered)
//   instr_count  : saturating retired-instruction counter (registered)
// -----------------------------------------------------------------------------
module uc_secuencial
    import uc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    uc_secuencial_if.master   bus,
    input  logic              start,
    input  logic              step_mode,
    input  logic              step,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            raw;
    logic             exec;
    logic             retire;

    uc_decode u_decode (
        .opcode (bus.Opcode),
        .zero   (bus.zero),
        .ctrl   (raw)
    );

    // A step pulse only counts once we are already in STEP; a pulse arriving
    // together with start in IDLE just moves the FSM and executes nothing.
    assign exec   = (state_q == ST_RUN) || ((state_q == ST_STEP) && step);
    assign retire = exec && !raw.is_halt;

    // Control outputs fall back to the "hold" word whenever exec is low,
    // which also covers the async-reset case since state_q resets to IDLE.
    assign bus.pc_en = retire;
    assign bus.we    = exec & raw.we;
    assign bus.wez   = exec & raw.wez;
    assign bus.s_inc = exec ? raw.s_inc  : 1'b1;
    assign bus.s_inm = exec ? raw.s_inm  : 1'b0;
    assign bus.ALUOp = exec ? raw.alu_op : 3'b000;

    assign halted      = (state_q == ST_HALT);
    assign instr_count = cnt_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = step_mode ? ST_STEP : ST_RUN;
            end
            ST_RUN: begin
                // HALT wins over a step_mode change in the same cycle
                if (raw.is_halt)    state_d = ST_HALT;
                else if (step_mode) state_d = ST_STEP;
            end
            ST_STEP: begin
                if (step && raw.is_halt) state_d = ST_HALT;
                else if (!step_mode)     state_d = ST_RUN;
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (retire && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_uc_secuencial.sv
// -----------------------------------------------------------------------------
// tb_uc_secuencial
// Scoreboard bench for uc_secuencial. Two instances (CNT_W=16 and CNT_W=4)
// receive identical stimulus; a behavioural model pushes expected outputs
// when stimulus is applied and they are popped and compared once the DUT
// outputs have settled, mid-cycle.
// -----------------------------------------------------------------------------
module tb_uc_secuencial;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        step_mode;
    logic        step;
    logic        halted16, halted4;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;

    uc_secuencial_if bus16 ();
    uc_secuencial_if bus4 ();

    uc_secuencial #(.CNT_W(16)) dut16 (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus16),
        .start       (start),
        .step_mode   (step_mode),
        .step        (step),
        .halted      (halted16),
        .instr_count (cnt16)
    );

    uc_secuencial #(.CNT_W(4)) dut4 (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus4),
        .start       (start),
        .step_mode   (step_mode),
        .step        (step),
        .halted      (halted4),
        .instr_count (cnt4)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_en;
        logic       we;
        logic       wez;
        logic       s_inc;
        logic       s_inm;
        logic [2:0] alu;
        logic       halted;
        logic [15:0] c16;
        logic [3:0]  c4;
    } exp_t;

    exp_t sb[$];

    int n_total = 0;
    int n_bad   = 0;
    int pc_en_tally = 0;

    // model state: 0 IDLE, 1 RUN, 2 STEP, 3 HALT
    int m_st  = 0;
    int m_c16 = 0;
    int m_c4  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic z, input logic st,
                         input logic sm, input logic sp);
        bus16.Opcode = op; bus4.Opcode = op;
        bus16.zero   = z;  bus4.zero   = z;
        start = st; step_mode = sm; step = sp;
    endtask

    // One clock cycle: entered at posedge+1, leaves at next posedge+1.
    task automatic cycle(input string tag, input logic [5:0] op, input logic z,
                         input logic st, input logic sm, input logic sp);
        exp_t e, g;
        logic ex, hlt, we_r, inm_r, sinc_r;
        logic [2:0] alu_r;
        drive(op, z, st, sm, sp);
        ex    = (m_st == 1) || (m_st == 2 && sp);
        hlt   = (op == 6'b111111);
        we_r  = (op[5] == 1'b0);
        inm_r = (op[5:4] == 2'b01);
        alu_r = op[5] ? 3'b000 : op[2:0];
        sinc_r = 1'b1;
        if (op[5:4] == 2'b10) begin
            if (op[1:0] == 2'b00) sinc_r = 1'b0;
            else if (op[1:0] == 2'b01) sinc_r = ~z;
            else if (op[1:0] == 2'b10) sinc_r = z;
        end
        e.pc_en  = ex && !hlt;
        e.we     = ex && we_r;
        e.wez    = ex && we_r;
        e.s_inc  = ex ? sinc_r : 1'b1;
        e.s_inm  = ex ? inm_r : 1'b0;
        e.alu    = ex ? alu_r : 3'b000;
        e.halted = (m_st == 3);
        e.c16    = 16'(m_c16);
        e.c4     = 4'(m_c4);
        sb.push_back(e);
        #3;
        g = sb.pop_front();
        check({tag, ".pc_en"},  bus16.pc_en, g.pc_en);
        check({tag, ".we"},     bus16.we,    g.we);
        check({tag, ".wez"},    bus16.wez,   g.wez);
        check({tag, ".s_inc"},  bus16.s_inc, g.s_inc);
        check({tag, ".s_inm"},  bus16.s_inm, g.s_inm);
        check({tag, ".alu"},    bus16.ALUOp, g.alu);
        check({tag, ".halted"}, halted16,    g.halted);
        check({tag, ".cnt16"},  cnt16,       g.c16);
        check({tag, ".cnt4"},   cnt4,        g.c4);
        check({tag, ".pc_en4"}, bus4.pc_en,  g.pc_en);
        if (bus16.pc_en) pc_en_tally++;
        @(posedge clk);
        #1;
        // model state update for the edge just taken
        if (e.pc_en) begin
            if (m_c16 < 65535) m_c16++;
            if (m_c4 < 15)     m_c4++;
        end
        case (m_st)
            0: if (st) m_st = sm ? 2 : 1;
            1: if (hlt) m_st = 3; else if (sm) m_st = 2;
            2: if (sp && hlt) m_st = 3; else if (!sm) m_st = 1;
            default: m_st = 3;
        endcase
    endtask

    // Asynchronous reset asserted mid-cycle; checks before the next edge.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        check({tag, ".pc_en"},  bus16.pc_en, 1'b0);
        check({tag, ".we"},     bus16.we,    1'b0);
        check({tag, ".wez"},    bus16.wez,   1'b0);
        check({tag, ".s_inc"},  bus16.s_inc, 1'b1);
        check({tag, ".s_inm"},  bus16.s_inm, 1'b0);
        check({tag, ".alu"},    bus16.ALUOp, 3'b000);
        check({tag, ".halted"}, halted16,    1'b0);
        check({tag, ".cnt16"},  cnt16,       16'd0);
        check({tag, ".cnt4"},   cnt4,        4'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_st = 0; m_c16 = 0; m_c4 = 0;
    endtask

    initial begin
        reset = 1'b0;
        drive(6'b000010, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        // reset held low from time zero: outputs must already be at reset values
        check("por.pc_en",  bus16.pc_en, 1'b0);
        check("por.we",     bus16.we,    1'b0);
        check("por.s_inc",  bus16.s_inc, 1'b1);
        check("por.cnt16",  cnt16,       16'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_st = 0; m_c16 = 0; m_c4 = 0;

        // start into RUN, then first ALU instruction
        cycle("idle_start", 6'b000010, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("alu_rr",     6'b000010, 1'b0, 1'b0, 1'b0, 1'b0);
        check("cnt_after_first", cnt16, 16'd1);
        // jumps
        cycle("jz_z1",   6'b100001, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("jz_z0",   6'b100001, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("jnz_z0",  6'b100010, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("jnz_z1",  6'b100010, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("j",       6'b101100, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("jres",    6'b100011, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("nop",     6'b110000, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("alu_im",  6'b011101, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("run_step_ignored", 6'b001011, 1'b0, 1'b0, 1'b0, 1'b1);
        // long ALU run: 4-bit counter must saturate at 15
        for (int i = 0; i < 20; i++) begin
            logic [5:0] op;
            op = 6'($urandom_range(0, 31));
            cycle($sformatf("alu_run%0d", i), op, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        end
        check("cnt4_sat", cnt4, 4'd15);
        // RUN -> STEP after current instruction, then back to RUN
        cycle("run_to_step", 6'b000101, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle("step_idle",   6'b000101, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle("step_to_run", 6'b000101, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("run_again",   6'b000110, 1'b0, 1'b0, 1'b0, 1'b0);
        // async reset in the middle of a RUN cycle
        drive(6'b000001, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("pre_rst.pc_en", bus16.pc_en, 1'b1);
        async_reset("mid_rst");
        cycle("post_rst_idle", 6'b000001, 1'b0, 1'b0, 1'b0, 1'b0);

        // step mode: start together with step must not consume that pulse
        cycle("start_step", 6'b000001, 1'b0, 1'b1, 1'b1, 1'b1);
        pc_en_tally = 0;
        for (int k = 0; k < 3; k++) begin
            cycle($sformatf("pulse%0d", k), 6'b000001, 1'b0, 1'b0, 1'b1, 1'b1);
            for (int j = 0; j < 3; j++)
                cycle($sformatf("gap%0d_%0d", k, j), 6'b000001, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        check("step_pc_en_cycles", pc_en_tally, 3);
        check("step_cnt", cnt16, 16'd3);
        // HALT under a step pulse
        cycle("step_halt",  6'b111111, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle("halted_chk", 6'b000000, 1'b0, 1'b1, 1'b0, 1'b1);
        check("halted_after_step", halted16, 1'b1);

        // HALT in RUN, then start ignored and counter frozen
        async_reset("rst2");
        cycle("run2_start", 6'b000000, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("run2_alu",   6'b000111, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("run2_halt",  6'b111111, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle($sformatf("halt_hold%0d", i), 6'b000000, 1'b0, 1'b1, 1'b0, 1'b0);
        check("halt_cnt_frozen", cnt16, 16'd1);
        check("halt_flag",       halted16, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/uc_secuencial.md
Name: uc_secuencial

Overview:
- Control unit for the single-cycle microcontroller datapath. Consumes Opcode[5:0] and the registered zero flag. Drives s_inc, s_inm, we, wez and ALUOp.
- Adds a run-control FSM (IDLE/RUN/STEP/HALT), a new pc_en output for the datapath PC, and a retired-instruction counter. These support start-up, single-step debug and HALT.

Parameters:
- CNT_W, 16, width of retired-instruction counter (saturating).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Opcode  in  6  instruction opcode field from the datapath.
- zero  in  1  registered ALU zero flag from the datapath.
- start  in  1  level; IDLE->RUN request.
- step_mode  in  1  when 1, execute one instruction per step pulse.
- step  in  1  single-cycle pulse; permits one instruction in step mode.
- s_inc  out  1  1: PC<=PC+1, 0: PC<=jump address.
- s_inm  out  1  1: immediate operand / RA1=WA3.
- we  out  1  register-file write enable.
- wez  out  1  zero-flag write enable.
- ALUOp  out  3  ALU operation.
- pc_en  out  1  PC register enable (datapath PC gains this enable).
- halted  out  1  1 while in HALT.
- instr_count  out  CNT_W  number of retired instructions.

Behaviour:
- Reset (reset=0, async) forces:
  - state=IDLE, instr_count=0.
  - pc_en=0, we=0, wez=0, s_inc=1, s_inm=0, ALUOp=0, halted=0.
- Decode is combinational from Opcode/zero. The raw decode is qualified by exec, defined as (state==RUN) or (state==STEP and step==1). When exec=0: pc_en=we=wez=0, s_inc=1.
- Opcode decode when exec=1:
  - 00_xaaa: reg-reg ALU. ALUOp=aaa, s_inm=0, we=1, wez=1, s_inc=1.
  - 01_xaaa: immediate ALU. ALUOp=aaa, s_inm=1, we=1, wez=1, s_inc=1.
  - 10_xx00: J. s_inc=0.
  - 10_xx01: JZ. s_inc=~zero.
  - 10_xx10: JNZ. s_inc=zero.
  - 10_xx11: reserved; treated as NOP.
  - For all jumps: we=0, wez=0.
  - 111111: HALT. pc_en=0, we=0, wez=0; next state HALT.
  - All other 11_xxxx: NOP. we=0, wez=0, s_inc=1.
- pc_en=1 whenever exec=1 and the opcode is not HALT.
- zero is the flag registered by the previous flag-writing instruction. A jump never updates it.
- FSM transitions:
  - IDLE: start=1 -> STEP if step_mode=1, else RUN.
  - RUN: HALT decoded -> HALT; step_mode=1 -> STEP (takes effect next cycle; the current instruction completes).
  - STEP: step_mode=0 -> RUN. A step pulse executes exactly one instruction; a HALT decoded under a step pulse -> HALT.
  - HALT: absorbing. Only reset leaves it; start is ignored.
- Simultaneous events:
  - start and step together in IDLE with step_mode=1: enter STEP only; that step pulse is not consumed.
  - step while in RUN: ignored.
- instr_count increments by 1 on each clock edge where exec=1 and the opcode is not HALT. It saturates at 2^CNT_W-1 and does not wrap.
- Reset mid-instruction: all outputs go to reset values immediately (async). The datapath PC resets in parallel.
- Latency:
  - Control outputs: 0 cycles (combinational from Opcode/state).
  - halted, instr_count: registered, 1 cycle.

Decomposition:
- Shared package uc_pkg holds:
  - Opcode class constants: OP_ALU_RR=2'b00, OP_ALU_IM=2'b01, OP_JMP=2'b10, OP_SYS=2'b11.
  - Jump subcodes: J=2'b00, JZ=2'b01, JNZ=2'b10.
  - OP_HALT=6'b111111.
  - FSM state encoding, 2 bits.
- One sub-module: uc_decode (purely combinational opcode/zero -> raw control word). The top holds the FSM, exec qualification and counter.

Test Plan:
- Reset then start=1 with step_mode=0, opcode 000010 -> from the next cycle: pc_en=1, we=1, wez=1, ALUOp=010, s_inm=0; instr_count = 1 after one edge.
- In RUN: opcode 100001 with zero=1 -> s_inc=0, we=0. Same opcode with zero=0 -> s_inc=1. Opcode 100010 with zero=0 -> s_inc=0.
- In RUN: opcode 111111 -> pc_en=0 that cycle, halted=1 next cycle. Then start=1 and opcode 000000 -> pc_en stays 0 and instr_count stays frozen.
- step_mode=1 with start, then 3 step pulses spaced 4 cycles apart -> pc_en=1 exactly 3 cycles, instr_count=3, we=0 in all other cycles.
- With CNT_W=4, run 20 ALU instructions -> instr_count stops at 15.
- Assert reset=0 asynchronously mid-cycle during RUN -> pc_en, we and wez drop before the next clock edge; instr_count=0; state IDLE (start needed again).
